irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL provide the following ports:
  - clk  in  1  system clock, all state on rising edge
  - reset_n  in  1  asynchronous active-low reset
  - en  in  1  bus access enable from busctrl
  - wr  in  1  1=write, 0=read; valid while en=1
  - addr[3:2]  in  2  register select
  - data_in  in  32  write data, bits [15:0] used
  - data_out  out  32  read data
  - wt  out  1  bus wait request
  - irq_in  in  16  raw device interrupt lines (tmr, dsk, kbd, ser0/1, ...)
  - irq_out  out  16  masked interrupt lines to cpu irq[15:0]
REQ-003 The block SHALL map its registers as follows (bits [31:16] read 0):
  - addr=0  PENDING
  - addr=1  MASK  r/w
  - addr=2  EDGE  r/w, 1=edge-triggered, 0=level
  - addr=3  STATUS  read-only

Function
REQ-004 Each irq_in bit SHALL pass through a two-flop synchronizer before any other use.
REQ-005 For an edge source, a PENDING bit SHALL be set on a 0->1 transition of its synchronized line and SHALL stay set until cleared.
REQ-006 For a level source, a PENDING bit SHALL equal its synchronized line, registered each cycle.
REQ-007 irq_out SHALL equal PENDING AND MASK, driven combinationally from registers.
REQ-008 An irq_in rise sampled at edge k SHALL appear on irq_out after edge k+3 when masked-in.
REQ-009 A write to PENDING SHALL be write-1-to-clear for edge bits and SHALL be ignored for level bits.
REQ-010 When an edge event and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-011 Clearing a MASK bit SHALL NOT clear PENDING.
REQ-012 Changing an EDGE bit 1->0 SHALL reload that PENDING bit from its synchronized level on the next cycle.
REQ-013 Changing an EDGE bit 0->1 SHALL keep the current PENDING value.
REQ-014 The bus handshake SHALL be a two-state FSM with states IDLE and ACK:
  - IDLE with en=1: wt=1, go to ACK.
  - ACK: wt=0, the write is committed at the end of the cycle, data_out is valid, return to IDLE.
REQ-015 wt SHALL be 0 whenever en=0.
REQ-016 Every access SHALL therefore take exactly 2 cycles.
REQ-017 If en remains 1 after ACK, a new access SHALL start from IDLE.
REQ-018 data_out SHALL be 0 whenever en=0 or wr=1.
REQ-019 Deassertion of en while in ACK SHALL return the FSM to IDLE with no register write.

Reset
REQ-020 While reset_n=0, the following SHALL be 0:
  - PENDING, MASK, EDGE
  - the synchronizer flops
  - the FSM (held in IDLE)
  - irq_out and wt
  - data_out
REQ-021 Reset asserted mid-access SHALL abort the access with no register write.
REQ-022 The block SHALL leave reset on the first clk rising edge after reset_n rises, with no spurious edge detected from the reset-zero synchronizer state.

Configuration
REQ-023 Macro IRQ_CTRL_STATUS_EN, when defined, SHALL enable the STATUS register:
  - bit 31 = 1 if any bit of PENDING AND MASK is set
  - bits [3:0] = highest set index of PENDING AND MASK, or 0 if none
REQ-024 Without IRQ_CTRL_STATUS_EN, addr=3 SHALL read 0, writes to it SHALL be ignored, and no priority encoder SHALL be synthesized.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
  - Reset, then read each of addr 0..2: each read returns 0x00000000, wt=1 then 0, and irq_out=0x0000.
  - Write MASK=0x4000, EDGE=0x4000; pulse irq_in[14] high for 1 cycle: PENDING=0x4000, irq_out[14]=1 three cycles later; write PENDING=0x4000: irq_out=0.
  - With EDGE=0 and MASK=0x0100, raise irq_in[8]: irq_out[8]=1; write PENDING=0x0100: no change; drop irq_in[8]: irq_out[8]=0 after 3 cycles.
  - With EDGE=0x0001, apply an edge on irq_in[0] in the same cycle as a W1C write of 0x0001: PENDING[0] remains 1.
  - With IRQ_CTRL_STATUS_EN and MASK=0xFFFF, pend bits 1 and 4: STATUS=0x80000004; clear MASK: STATUS=0x00000000.
  - Assert reset_n=0 during the ACK of a write of MASK=0xFFFF: MASK reads 0 after reset.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes 16 raw lines into PENDING (edge/level per EDGE bit), masks to irq_out.
// Optional STATUS register (any-pending flag + highest index) enabled by `define IRQ_CTRL_STATUS_EN.
module irq_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        wr,
  input  logic [3:2]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        wt,
  input  logic [15:0] irq_in,
  output logic [15:0] irq_out
);

  localparam int unsigned NIRQ = 16;
  localparam int unsigned DW   = 32;

  localparam logic [1:0] A_PEND   = 2'd0;
  localparam logic [1:0] A_MASK   = 2'd1;
  localparam logic [1:0] A_EDGE   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [NIRQ-1:0]   sync1, sync2, hist, rise_q;
  logic [NIRQ-1:0]   pending, mask, edge_mode;
  logic [NIRQ-1:0]   pend_nxt, clr;
  logic [1:0]        warm;
  logic              armed;
  logic              commit;
  logic [DW-1:0]     rdata, status;
  logic              unused_hi;

  assign unused_hi = ^data_in[DW-1:NIRQ];

  // Edge detection stays disarmed until sync1/sync2/hist all hold real input, so reset zeros never look like a rise.
  assign armed = (warm == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      hist   <= '0;
      rise_q <= '0;
      warm   <= '0;
    end else begin
      sync1  <= irq_in;
      sync2  <= sync1;
      hist   <= sync2;
      rise_q <= armed ? (sync2 & ~hist) : '0;
      if (!armed) warm <= warm + 2'd1;
    end
  end

  // Bus handshake state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wt        = 1'b0;
    data_out  = '0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          wt        = reset_n;
          state_nxt = ACK;
        end
      end
      ACK: begin
        state_nxt = IDLE;
        if (en) begin
          commit = wr;
          if (!wr) data_out = rdata;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Edge bits: W1C with a same-cycle set winning; level bits simply track the synchronized line.
  always_comb begin
    clr      = (commit && addr == A_PEND) ? data_in[NIRQ-1:0] : '0;
    pend_nxt = (edge_mode & ((pending & ~clr) | rise_q)) | (~edge_mode & hist);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending   <= '0;
      mask      <= '0;
      edge_mode <= '0;
    end else begin
      pending <= pend_nxt;
      if (commit && addr == A_MASK) mask      <= data_in[NIRQ-1:0];
      if (commit && addr == A_EDGE) edge_mode <= data_in[NIRQ-1:0];
    end
  end

  assign irq_out = pending & mask;

`ifdef IRQ_CTRL_STATUS_EN
  logic [3:0] hi_idx;

  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (irq_out[i]) hi_idx = 4'(i);
    end
  end

  assign status = {|irq_out, 27'd0, hi_idx};
`else
  assign status = '0;
`endif

  always_comb begin
    rdata = '0;
    case (addr)
      A_PEND:   rdata = {16'd0, pending};
      A_MASK:   rdata = {16'd0, mask};
      A_EDGE:   rdata = {16'd0, edge_mode};
      A_STATUS: rdata = status;
      default:  rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: bus handshake, edge/level pending, W1C priority, STATUS, reset abort.
module tb_irq_ctrl;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        wr;
  logic [3:2]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        wt;
  logic [15:0] irq_in;
  logic [15:0] irq_out;

  int n_vec = 0;
  int n_err = 0;

`ifdef IRQ_CTRL_STATUS_EN
  localparam logic [31:0] STAT_14 = 32'h8000_0004;
`else
  localparam logic [31:0] STAT_14 = 32'h0000_0000;
`endif

  irq_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .wt       (wt),
    .irq_in   (irq_in),
    .irq_out  (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    en   = 1'b1;
    wr   = 1'b0;
    addr = a;
    @(negedge clk);
    check({tag, "_wt1"}, 32'(wt), 32'd1);
    tick();
    @(negedge clk);
    check({tag, "_wt0"}, 32'(wt), 32'd0);
    check(tag, data_out, exp);
    tick();
    en = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    en      = 1'b1;
    wr      = 1'b1;
    addr    = a;
    data_in = d;
    tick();
    @(negedge clk);
    check("wr_dout0", data_out, 32'd0);
    tick();
    en      = 1'b0;
    wr      = 1'b0;
    data_in = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    data_in = '0;
    irq_in  = '0;
    #12;
    check("rst_irq", 32'(irq_out), 32'd0);
    check("rst_wt", 32'(wt), 32'd0);
    check("rst_dout", data_out, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) tick();

    bus_read("rd_pend0", 2'd0, 32'd0);
    bus_read("rd_mask0", 2'd1, 32'd0);
    bus_read("rd_edge0", 2'd2, 32'd0);
    check("irq_idle", 32'(irq_out), 32'd0);

    // edge source on line 14, one-cycle pulse
    bus_write(2'd1, 32'h4000);
    bus_write(2'd2, 32'h4000);
    irq_in = 16'h4000;
    tick();
    irq_in = 16'h0000;
    tick();
    tick();
    check("edge_k2", 32'(irq_out), 32'h0000);
    tick();
    check("edge_k3", 32'(irq_out), 32'h4000);
    bus_read("pend_edge", 2'd0, 32'h4000);
    bus_write(2'd1, 32'h0);
    check("mask_off", 32'(irq_out), 32'h0000);
    bus_read("pend_kept", 2'd0, 32'h4000);
    bus_write(2'd1, 32'h4000);
    check("mask_on", 32'(irq_out), 32'h4000);
    bus_write(2'd0, 32'h4000);
    check("edge_w1c", 32'(irq_out), 32'h0000);
    bus_read("pend_clr", 2'd0, 32'h0);

    // level source on line 8
    bus_write(2'd2, 32'h0);
    bus_write(2'd1, 32'h0100);
    irq_in = 16'h0100;
    tick();
    tick();
    tick();
    check("lvl_k2", 32'(irq_out), 32'h0000);
    tick();
    check("lvl_k3", 32'(irq_out), 32'h0100);
    bus_write(2'd0, 32'h0100);
    check("lvl_w1c", 32'(irq_out), 32'h0100);
    irq_in = 16'h0000;
    tick();
    tick();
    tick();
    check("lvl_hold", 32'(irq_out), 32'h0100);
    tick();
    check("lvl_drop", 32'(irq_out), 32'h0000);

    // rise on line 0 lands on the same edge as a W1C of bit 0
    bus_write(2'd2, 32'h0001);
    bus_write(2'd1, 32'h0001);
    irq_in = 16'h0001;
    tick();
    tick();
    bus_write(2'd0, 32'h0001);
    check("set_wins", 32'(irq_out), 32'h0001);
    bus_read("pend_set", 2'd0, 32'h0001);
    bus_write(2'd0, 32'h0001);
    check("clr_after", 32'(irq_out), 32'h0000);

    // STATUS with level lines 1 and 4 pending
    irq_in = 16'h0013;
    bus_write(2'd1, 32'hFFFF);
    bus_write(2'd3, 32'hFFFF);
    tick();
    tick();
    bus_read("pend_14", 2'd0, 32'h0012);
    check("irq_14", 32'(irq_out), 32'h0012);
    bus_read("status_14", 2'd3, STAT_14);
    bus_write(2'd1, 32'h0);
    bus_read("status_off", 2'd3, 32'h0);

    // EDGE 1->0 reloads bit 0 from its held-high line
    bus_write(2'd2, 32'h0);
    bus_read("edge_reload", 2'd0, 32'h0013);

    // en dropped during ACK: no write
    en      = 1'b1;
    wr      = 1'b1;
    addr    = 2'd1;
    data_in = 32'h00FF;
    tick();
    en = 1'b0;
    @(negedge clk);
    check("drop_wt", 32'(wt), 32'd0);
    tick();
    wr      = 1'b0;
    data_in = '0;
    bus_read("drop_mask", 2'd1, 32'h0);

    // reset asserted during ACK of MASK=0xFFFF
    irq_in  = '0;
    en      = 1'b1;
    wr      = 1'b1;
    addr    = 2'd1;
    data_in = 32'hFFFF;
    tick();
    reset_n = 1'b0;
    #2;
    check("rstmid_wt", 32'(wt), 32'd0);
    check("rstmid_dout", data_out, 32'd0);
    check("rstmid_irq", 32'(irq_out), 32'd0);
    @(posedge clk);
    #1;
    en      = 1'b0;
    wr      = 1'b0;
    data_in = '0;
    reset_n = 1'b1;
    repeat (4) tick();
    bus_read("rst_mask", 2'd1, 32'h0);
    bus_read("rst_pend", 2'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
